dac_play_seq: RTL



---
 rtl/dac_play_seq_pkg.sv | 20 ++
 rtl/dac_play_seq_sync_edge_det.sv | 42 ++++
 rtl/dac_play_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dac_play_seq_pkg.sv
// Shared codes for the DAC playback sequencer: FSM state encoding and trigger-source selects.
// Pure definitions; no latency and no flow control.
package dac_play_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] TRIG_SW    = 2'd0;
    localparam logic [1:0] TRIG_EXT_R = 2'd1;
    localparam logic [1:0] TRIG_EXT_F = 2'd2;
    localparam logic [1:0] TRIG_AUTO  = 2'd3;

    localparam logic [7:0] MISS_MAX = 8'hff;

endpackage

// File: rtl/dac_play_seq_sync_edge_det.sv
// Synchronizes an async level and emits registered one-cycle rise/fall pulses, STG+1 cycles after the pin edge.
// Free-running; no backpressure.
module sync_edge_det #(
    parameter int STG = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic [STG-1:0] sync_q, sync_d;
    logic           prev_q, prev_d;
    logic           rise_q, rise_d;
    logic           fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STG-2:0], i_din};
        prev_d = sync_q[STG-1];
        rise_d = sync_q[STG-1] & ~prev_q;
        fall_d = ~sync_q[STG-1] & prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/dac_play_seq.sv
// DAC waveform playback sequencer: arm, trigger, start delay, N repetitions of the address ramp.
// All outputs registered, first o_play = trigger cycle + 1 + delay; no backpressure (RAM read port always ready).
module dac_play_seq
    import dac_play_seq_pkg::*;
#(
    parameter int AW       = 13,
    parameter int DLY_W    = 32,
    parameter int REP_W    = 16,
    parameter int SYNC_STG = 2
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_sw_trig,
    input  logic             i_sync,
    input  logic [1:0]       i_trig_src,
    input  logic             i_cont,
    input  logic [DLY_W-1:0] i_delay,
    input  logic [AW-1:0]    i_len,
    input  logic [REP_W-1:0] i_nrep,
    output logic [AW-1:0]    o_addr,
    output logic             o_play,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_state,
    output logic [7:0]       o_miss_cnt
);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    len_q, len_d;
    logic [REP_W-1:0] nrep_q, nrep_d;
    logic             play_q, play_d;
    logic             done_q, done_d;
    logic [7:0]       miss_q, miss_d;

    logic ext_rise, ext_fall, trig_evt;

    sync_edge_det #(.STG(SYNC_STG)) u_sync (
        .i_clk  (i_clk),
        .i_clr  (i_clr),
        .i_din  (i_sync),
        .o_rise (ext_rise),
        .o_fall (ext_fall)
    );

    always_comb begin
        case (i_trig_src)
            TRIG_SW:    trig_evt = i_sw_trig;
            TRIG_EXT_R: trig_evt = ext_rise;
            TRIG_EXT_F: trig_evt = ext_fall;
            default:    trig_evt = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        nrep_d  = nrep_q;
        play_d  = 1'b0;
        done_d  = 1'b0;
        miss_d  = miss_q;

        case (state_q)
            ST_IDLE: begin
                if (i_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trig_evt) begin
                    len_d  = i_len;
                    nrep_d = i_nrep;
                    rep_d  = '0;
                    if (i_delay == '0) begin
                        state_d = ST_PLAY;
                        play_d  = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = i_delay - DLY_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                    play_d  = 1'b1;
                    rep_d   = '0;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            ST_PLAY: begin
                play_d = 1'b1;
                if (addr_q == len_q) begin
                    // nrep of zero never terminates; only abort leaves PLAY then
                    if (nrep_q != '0 && rep_q == nrep_q - REP_W'(1)) begin
                        state_d = ST_DONE;
                        play_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = i_cont ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Auto trigger is always asserted, so it would flood the miss counter
        if (trig_evt && state_q != ST_ARMED && i_trig_src != TRIG_AUTO && miss_q != MISS_MAX)
            miss_d = miss_q + 8'd1;

        if (i_abort) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            play_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            nrep_q  <= '0;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            nrep_q  <= nrep_d;
            play_q  <= play_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_play     = play_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_state    = state_q;
    assign o_miss_cnt = miss_q;

endmodule
